// File: rtl/switch_debounce_pkg.sv
// switch_debounce_pkg: shared switch sizing, debounce defaults and switch peripheral address offsets.
package switch_debounce_pkg;
    localparam int SWITCH_NBITS        = 24;
    localparam int SWITCH_TICK_DIV     = 23000;
    localparam int SWITCH_STABLE_TICKS = 8;
    localparam logic [3:0] SWITCH_DATA_OFF = 4'h0;
    localparam logic [3:0] SWITCH_CHG_OFF  = 4'h4;

    function automatic int cnt_width(input int stable_ticks);
        return $clog2(stable_ticks) + 1;
    endfunction
endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: 2-FF synchronizer plus tick-driven stability filter for one switch pin.
module debounce_bit
    import switch_debounce_pkg::*;
#(
    parameter int STABLE_TICKS = SWITCH_STABLE_TICKS
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tick_i,
    input  logic raw_i,
    output logic stable_o,
    output logic commit_o
);
    localparam int CW = cnt_width(STABLE_TICKS);
    localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);

    logic sync1_q, sync2_q, stable_q, stable_d, diff;
    logic [CW-1:0] cnt_q, cnt_d;

    assign diff     = sync2_q != stable_q;
    assign commit_o = tick_i && diff && cnt_q == LAST;
    assign stable_o = stable_q;

    // any tick that sees the settled level restarts the run
    always_comb begin
        cnt_d    = !tick_i ? cnt_q : (!diff || commit_o) ? '0 : cnt_q + CW'(1);
        stable_d = commit_o ? sync2_q : stable_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end
endmodule

// File: rtl/switch_debounce.sv
// switch_debounce: per-bit debounced DIP switches with a shared sample prescaler and change reporting.
module switch_debounce
    import switch_debounce_pkg::*;
#(
    parameter int NBITS        = SWITCH_NBITS,
    parameter int TICK_DIV     = SWITCH_TICK_DIV,
    parameter int STABLE_TICKS = SWITCH_STABLE_TICKS
) (
    input  logic             switclk,
    input  logic             switrst,
    input  logic [NBITS-1:0] switch_raw,
    input  logic             chg_clr,
    output logic [NBITS-1:0] switch_o,
    output logic             switch_chg,
    output logic [NBITS-1:0] chg_mask
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [NBITS-1:0] commit, mask_q, mask_d;
    logic tick, chg_q, chg_d;

    assign tick = pcnt_q == PLAST;

    for (genvar i = 0; i < NBITS; i++) begin : g_bit
        debounce_bit #(.STABLE_TICKS(STABLE_TICKS)) u_bit (
            .clk_i   (switclk),
            .rst_i   (switrst),
            .tick_i  (tick),
            .raw_i   (switch_raw[i]),
            .stable_o(switch_o[i]),
            .commit_o(commit[i])
        );
    end

    // a commit in the clear cycle survives so no change is ever lost
    always_comb begin
        pcnt_d = tick ? '0 : pcnt_q + PW'(1);
        chg_d  = |commit;
        mask_d = (chg_clr ? '0 : mask_q) | commit;
    end

    always_ff @(posedge switclk) begin
        if (switrst) begin
            pcnt_q <= '0;
            chg_q  <= 1'b0;
            mask_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
            chg_q  <= chg_d;
            mask_q <= mask_d;
        end
    end

    assign switch_chg = chg_q;
    assign chg_mask   = mask_q;
endmodule

// File: tb/tb_switch_debounce.sv
// tb_switch_debounce: table vectors, corner sequences and random stimulus against a run-length model.
module tb_switch_debounce;
    localparam int NB = 24;
    localparam int TD = 4;
    localparam int ST = 3;

    typedef struct {
        logic          rst;
        logic [NB-1:0] raw;
        logic          clr;
        logic [NB-1:0] e_o;
        logic          e_chg;
        logic [NB-1:0] e_mask;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    logic [NB-1:0] raw = '1;
    logic [NB-1:0] switch_o, chg_mask;
    logic switch_chg;

    int passed = 0;
    int total = 0;

    logic [NB-1:0] m_s1 = '0, m_s2 = '0, m_stable = '0, m_mask = '0;
    logic m_chg = 1'b0;
    int m_cycles = 0;
    int m_run[NB];

    switch_debounce #(.NBITS(NB), .TICK_DIV(TD), .STABLE_TICKS(ST)) dut (
        .switclk   (clk),
        .switrst   (rst),
        .switch_raw(raw),
        .chg_clr   (clr),
        .switch_o  (switch_o),
        .switch_chg(switch_chg),
        .chg_mask  (chg_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // a bit flips after ST consecutive sample ticks disagree with it; samples lag raw by two cycles
    task automatic model_edge();
        logic [NB-1:0] com;
        com = '0;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_stable = '0; m_mask = '0; m_chg = 1'b0; m_cycles = 0;
            for (int i = 0; i < NB; i++) m_run[i] = 0;
        end else begin
            if (m_cycles % TD == TD - 1)
                for (int i = 0; i < NB; i++) begin
                    if (m_s2[i] != m_stable[i]) begin
                        m_run[i]++;
                        if (m_run[i] == ST) begin
                            com[i] = 1'b1;
                            m_run[i] = 0;
                        end
                    end else m_run[i] = 0;
                end
            m_cycles++;
            m_stable = m_stable ^ com;
            m_chg = |com;
            m_mask = (clr ? '0 : m_mask) | com;
            m_s2 = m_s1;
            m_s1 = raw;
        end
    endtask

    function automatic bit commit_next(input int i);
        return !rst && (m_cycles % TD == TD - 1) && m_s2[i] != m_stable[i] && m_run[i] == ST - 1;
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        chk("model_o", 32'(switch_o), 32'(m_stable));
        chk("model_chg", 32'(switch_chg), 32'(m_chg));
        chk("model_mask", 32'(chg_mask), 32'(m_mask));
    endtask

    initial begin
        vec_t tbl[17];
        int lat, lat16, lat23, pulses;
        bit done;
        for (int r = 0; r < 3; r++) tbl[r] = '{1'b1, '1, 1'b0, '0, 1'b0, '0};
        for (int r = 3; r < 14; r++) tbl[r] = '{1'b0, '1, 1'b0, '0, 1'b0, '0};
        tbl[14] = '{1'b0, '1, 1'b0, '1, 1'b1, '1};
        tbl[15] = '{1'b0, '1, 1'b0, '1, 1'b0, '1};
        tbl[16] = '{1'b0, '1, 1'b1, '1, 1'b0, '0};

        for (int r = 0; r < 17; r++) begin
            rst = tbl[r].rst; raw = tbl[r].raw; clr = tbl[r].clr;
            cyc();
            chk($sformatf("tbl%0d_o", r), 32'(switch_o), 32'(tbl[r].e_o));
            chk($sformatf("tbl%0d_chg", r), 32'(switch_chg), 32'(tbl[r].e_chg));
            chk($sformatf("tbl%0d_mask", r), 32'(chg_mask), 32'(tbl[r].e_mask));
        end
        clr = 1'b0;

        // clean rising edge on bit 0
        raw[0] = 1'b0;
        repeat (20) cyc();
        clr = 1'b1; cyc(); clr = 1'b0;
        raw[0] = 1'b1;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (lat == 0 && switch_o[0]) begin
                lat = k;
                chk("s2_chg", 32'(switch_chg), 32'd1);
                chk("s2_mask", 32'(chg_mask), 32'h000001);
            end
        end
        chk("s2_lat_in_11_14", 32'(lat >= 11 && lat <= 14), 32'd1);

        // short glitch on bit 5 must vanish
        raw = 24'h000001;
        repeat (20) cyc();
        clr = 1'b1; cyc(); clr = 1'b0;
        raw[5] = 1'b1;
        repeat (6) cyc();
        raw[5] = 1'b0;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            pulses += int'(switch_chg);
        end
        chk("s3_o", 32'(switch_o), 32'h000001);
        chk("s3_pulses", 32'(pulses), 32'd0);
        chk("s3_mask", 32'(chg_mask), 32'h0);

        // two bits toggled together
        raw[23] = 1'b1; raw[16] = 1'b1;
        pulses = 0; lat16 = 0; lat23 = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            pulses += int'(switch_chg);
            if (lat16 == 0 && switch_o[16]) lat16 = k;
            if (lat23 == 0 && switch_o[23]) lat23 = k;
        end
        chk("s4_pulses", 32'(pulses), 32'd1);
        chk("s4_same_cycle", 32'(lat16), 32'(lat23));
        chk("s4_seen", 32'(lat16 != 0), 32'd1);
        chk("s4_mask", 32'(chg_mask), 32'h810000);

        // clear lands on the commit cycle of bit 7
        raw[3] = 1'b1;
        repeat (20) cyc();
        chk("s5_pre_mask", 32'(chg_mask), 32'h810008);
        raw[7] = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            clr = commit_next(7);
            cyc();
            if (clr) begin
                done = 1'b1;
                chk("s5_mask", 32'(chg_mask), 32'h000080);
            end
            clr = 1'b0;
        end
        chk("s5_commit_found", 32'(done), 32'd1);

        // reset with a partial count on bit 1
        raw[1] = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            cyc();
            done = m_run[1] == 2;
        end
        chk("s6_partial_found", 32'(done), 32'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("s6_rst_o", 32'(switch_o), 32'h0);
        chk("s6_rst_chg", 32'(switch_chg), 32'd0);
        chk("s6_rst_mask", 32'(chg_mask), 32'h0);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (lat == 0 && switch_o[1]) lat = k;
        end
        chk("s6_lat", 32'(lat), 32'd12);

        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(7) == 0) raw[$urandom_range(NB - 1)] ^= 1'b1;
            clr = $urandom_range(15) == 0;
            rst = $urandom_range(299) == 0;
            cyc();
        end
        rst = 1'b0; clr = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
